// File: rtl/my_deser_pkg.sv
// Shared types and constants for the single-wire serial word receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Optional parity support is enabled with the MY_DESER_RX_PARITY_EN macro.
package my_deser_pkg;

    localparam int DEFAULT_WIDTH = 16;

    // Line levels of the framed bit stream.
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DATA      = 3'd1,
        STOP      = 3'd2,
        WAIT_IDLE = 3'd3
`ifdef MY_DESER_RX_PARITY_EN
        ,
        PARITY    = 3'd4
`endif
    } state_e;

endpackage

// File: rtl/my_deser_hold.sv
// One-word holding register between the receive FSM and a valid/ready consumer.
// Latency: a loaded word is visible on out_data/out_valid one edge after load_vld.
// Backpressure: a load while full and out_ready=0 is dropped and pulses overrun for one cycle.
// Ports: clk, rst_n; load_vld/load_dat from the FSM; out_data/out_valid/out_ready to the
// consumer; overrun registered pulse.
module my_deser_hold #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_vld,
    input  logic [WIDTH-1:0] load_dat,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             overrun
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (load_vld) begin
            // A word leaving on this same edge frees the slot for the new one.
            if (!valid_q || out_ready) begin
                data_d  = load_dat;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign overrun   = overrun_q;

endmodule

// File: rtl/my_deser_rx.sv
// Serial word receiver: start bit, WIDTH data bits LSB first, stop bit, one bit per clock.
// Latency: out_valid rises WIDTH+2 edges after the start-bit edge (WIDTH+3 with parity).
// Backpressure: one-word holding register; a word completing while it is full and not
// being accepted is dropped with an overrun pulse.
// Ports: clk, rst_n; serial_in line; out_data/out_valid/out_ready word port;
// frame_err, overrun (and parity_err) one-cycle pulses; busy when not IDLE.
// Build option MY_DESER_RX_PARITY_EN inserts an even-parity bit before the stop bit.
module my_deser_rx
    import my_deser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial_in,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
`ifdef MY_DESER_RX_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             frame_err_q, frame_err_d;
    logic             word_vld;

`ifdef MY_DESER_RX_PARITY_EN
    logic             par_q, par_d;          // running XOR of data bits
    logic             par_ok_q, par_ok_d;    // sampled parity bit made the total even
    logic             parity_err_q, parity_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        word_vld    = 1'b0;
`ifdef MY_DESER_RX_PARITY_EN
        par_d        = par_q;
        par_ok_d     = par_ok_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (serial_in == START_BIT) begin
                    state_d = DATA;
                    cnt_d   = '0;
`ifdef MY_DESER_RX_PARITY_EN
                    par_d   = 1'b0;
`endif
                end
            end
            DATA: begin
                // Right shift: after WIDTH bits the first (LSB) bit sits in bit 0.
                shift_d = {serial_in, shift_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CNT_W'(1);
`ifdef MY_DESER_RX_PARITY_EN
                par_d   = par_q ^ serial_in;
`endif
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef MY_DESER_RX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef MY_DESER_RX_PARITY_EN
            PARITY: begin
                par_ok_d = ((par_q ^ serial_in) == 1'b0);
                state_d  = STOP;
            end
`endif
            STOP: begin
`ifdef MY_DESER_RX_PARITY_EN
                // A parity mismatch is reported whatever the stop bit turns out to be.
                parity_err_d = !par_ok_q;
`endif
                if (serial_in == STOP_BIT) begin
                    state_d = IDLE;
`ifdef MY_DESER_RX_PARITY_EN
                    word_vld = par_ok_q;
`else
                    word_vld = 1'b1;
`endif
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                // Low bits here belong to the broken frame and never start a new one.
                if (serial_in == IDLE_LEVEL) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef MY_DESER_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q        <= 1'b0;
            par_ok_q     <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_q        <= par_d;
            par_ok_q     <= par_ok_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`endif

    my_deser_hold #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_vld  (word_vld),
        .load_dat  (shift_q),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .overrun   (overrun)
    );

    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule
